// File: rtl/attn_proj_scheduler.sv
// -----------------------------------------------------------------------------
// attn_proj_scheduler
//
// Runs the Q, K and V projection engines one after another (they share the
// input SRAM) and writes each 512-bit result tile into the projection output
// SRAM as four consecutive 128-bit words. Engine e owns the address region
// starting at e*TILES*4; tile t of that engine occupies words 4t..4t+3, with
// the least-significant 128 bits written first.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, cfg_mask     pass request and engine selection (bit0=Q, 1=K, 2=V)
//   busy, done, err     pass status; err is sticky until the next accepted start
//   eng_en              one-hot, one-cycle engine start pulse
//   eng_valid           per-engine tile-valid pulses
//   q_tile/k_tile/v_tile engine result tiles
//   OUT_MEM_*           output SRAM port (active-low CEB/WEN), all registered
// -----------------------------------------------------------------------------
module attn_proj_scheduler #(
    parameter int TILES  = 32,
    parameter int OUT_AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        cfg_mask,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        eng_en,
    input  logic [2:0]        eng_valid,
    input  logic [511:0]      q_tile,
    input  logic [511:0]      k_tile,
    input  logic [511:0]      v_tile,
    output logic              OUT_MEM_CEB,
    output logic              OUT_MEM_WEN,
    output logic [OUT_AW-1:0] OUT_MEM_ADDR,
    output logic [127:0]      OUT_MEM_DIN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam int                CW        = (TILES > 1) ? $clog2(TILES) : 1;
    localparam logic [CW-1:0]     LAST_TILE = CW'(TILES - 1);
    localparam logic [OUT_AW-1:0] STRIDE    = OUT_AW'(TILES * 4);

    state_t              state_q, state_d;
    logic [2:0]          mask_q, mask_d;
    logic [1:0]          sel_q, sel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          beat_q, beat_d;
    logic [511:0]        tile_q, tile_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [2:0]          en_q, en_d;
    logic                ceb_q, ceb_d;
    logic                wen_q, wen_d;
    logic [OUT_AW-1:0]   addr_q, addr_d;
    logic [127:0]        din_q, din_d;

    logic [511:0]        tile_in;
    logic [2:0]          sel_oh;

    function automatic logic [2:0] onehot(input logic [1:0] s);
        case (s)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    // An empty mask has no lowest bit; sel is then irrelevant and stays 0.
    function automatic logic [1:0] lowest_bit(input logic [2:0] m);
        if (m[0])      lowest_bit = 2'd0;
        else if (m[1]) lowest_bit = 2'd1;
        else if (m[2]) lowest_bit = 2'd2;
        else           lowest_bit = 2'd0;
    endfunction

    function automatic logic [127:0] slice128(input logic [511:0] t, input logic [1:0] b);
        case (b)
            2'd0:    slice128 = t[127:0];
            2'd1:    slice128 = t[255:128];
            2'd2:    slice128 = t[383:256];
            default: slice128 = t[511:384];
        endcase
    endfunction

    function automatic logic [OUT_AW-1:0] region_base(input logic [1:0] s);
        case (s)
            2'd0:    region_base = '0;
            2'd1:    region_base = STRIDE;
            default: region_base = STRIDE + STRIDE;
        endcase
    endfunction

    assign sel_oh = onehot(sel_q);

    always_comb begin
        case (sel_q)
            2'd0:    tile_in = q_tile;
            2'd1:    tile_in = k_tile;
            default: tile_in = v_tile;
        endcase
    end

    // Next-state logic. All outputs are registered from next-state values so
    // that eng_en / SRAM strobes appear in the cycle the FSM enters a state.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        tile_d  = tile_q;
        err_d   = err_q;
        ceb_d   = 1'b1;
        wen_d   = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = cfg_mask;
                    sel_d   = lowest_bit(cfg_mask);
                    err_d   = 1'b0;
                    state_d = (cfg_mask == 3'b000) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid[sel_q]) begin
                    tile_d  = tile_in;
                    beat_d  = 2'd0;
                    ceb_d   = 1'b0;
                    wen_d   = 1'b0;
                    addr_d  = region_base(sel_q) + OUT_AW'({cnt_q, 2'b00});
                    din_d   = tile_in[127:0];
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (beat_q != 2'd3) begin
                    beat_d = beat_q + 2'd1;
                    ceb_d  = 1'b0;
                    wen_d  = 1'b0;
                    addr_d = addr_q + OUT_AW'(1);
                    din_d  = slice128(tile_q, beat_q + 2'd1);
                end else if (cnt_q != LAST_TILE) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                // Engines always run in Q, K, V order: only look above sel.
                state_d = S_DONE;
                if (sel_q == 2'd0 && mask_q[1]) begin
                    sel_d   = 2'd1;
                    state_d = S_LAUNCH;
                end else if (sel_q != 2'd2 && mask_q[2]) begin
                    sel_d   = 2'd2;
                    state_d = S_LAUNCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only a selected-engine valid while waiting is legal; anything else
        // is flagged and otherwise ignored.
        if ((eng_valid != 3'b000) &&
            ((state_q != S_WAIT) || ((eng_valid & ~sel_oh) != 3'b000))) begin
            err_d = 1'b1;
        end

        en_d   = (state_d == S_LAUNCH) ? onehot(sel_d) : 3'b000;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= 3'b000;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            beat_q  <= 2'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 3'b000;
            ceb_q   <= 1'b1;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            ceb_q   <= ceb_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Tile buffer is pure data and needs no reset.
    always_ff @(posedge clk) begin
        tile_q <= tile_d;
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign eng_en       = en_q;
    assign OUT_MEM_CEB  = ceb_q;
    assign OUT_MEM_WEN  = wen_q;
    assign OUT_MEM_ADDR = addr_q;
    assign OUT_MEM_DIN  = din_q;

endmodule

// File: tb/tb_attn_proj_scheduler.sv
module tb_attn_proj_scheduler;

    localparam int TILES = 32;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    cfg_mask;
    logic          busy, done, err;
    logic [2:0]    eng_en;
    logic [2:0]    eng_valid;
    logic [511:0]  q_tile, k_tile, v_tile;
    logic          OUT_MEM_CEB, OUT_MEM_WEN;
    logic [AW-1:0] OUT_MEM_ADDR;
    logic [127:0]  OUT_MEM_DIN;

    attn_proj_scheduler #(.TILES(TILES), .OUT_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mask(cfg_mask),
        .busy(busy), .done(done), .err(err), .eng_en(eng_en),
        .eng_valid(eng_valid), .q_tile(q_tile), .k_tile(k_tile), .v_tile(v_tile),
        .OUT_MEM_CEB(OUT_MEM_CEB), .OUT_MEM_WEN(OUT_MEM_WEN),
        .OUT_MEM_ADDR(OUT_MEM_ADDR), .OUT_MEM_DIN(OUT_MEM_DIN)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
    } wr_t;

    typedef struct {
        logic [2:0] mask;
        int         en_n;
        int         wr_n;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    wr_t        exp_q[$];
    logic [2:0] en_log[$];
    vec_t       vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tile t of engine e: sixteen 32-bit words {0xA0+e, t, word index}.
    function automatic logic [511:0] tdata(input int e, input int t);
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = {8'(160 + e), 8'(t), 16'(w)};
        return r;
    endfunction

    function automatic wr_t mk_wr(input int e, input int t, input int b);
        wr_t       x;
        logic [511:0] d;
        d      = tdata(e, t);
        x.addr = AW'(e * TILES * 4 + t * 4 + b);
        x.data = d[128*b +: 128];
        return x;
    endfunction

    task automatic drive_tile(input int e, input int t);
        logic [2:0] oh;
        oh = 3'b001 << e;
        q_tile    = tdata(0, t);
        k_tile    = tdata(1, t);
        v_tile    = tdata(2, t);
        eng_valid = oh;
        tick();
        eng_valid = 3'b000;
    endtask

    // Output monitor: every SRAM access must match the next expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!OUT_MEM_CEB) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual addr=%0d required no write", OUT_MEM_ADDR);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 128'(OUT_MEM_ADDR), 128'(e.addr));
                    chk("wr_data", OUT_MEM_DIN, e.data);
                    chk("wr_wen", 128'(OUT_MEM_WEN), 0);
                end
            end
            if (eng_en != 3'b000) en_log.push_back(eng_en);
            if (done) done_cnt++;
        end
    end

    task automatic run_pass(input logic [2:0] mask, input int exp_en_n, input int exp_wr_n);
        int cnt;
        int idx;
        bit first;
        exp_q.delete();
        en_log.delete();
        done_cnt = 0;
        wr_cnt   = 0;
        for (int e = 0; e < 3; e++)
            if (mask[e])
                for (int t = 0; t < TILES; t++)
                    for (int b = 0; b < 4; b++) exp_q.push_back(mk_wr(e, t, b));

        cfg_mask = mask;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cfg_mask = 3'b000;
        chk("err_cleared_by_start", 128'(err), 0);

        if (mask == 3'b000) begin
            chk("empty_done", 128'(done), 1);
            chk("empty_busy", 128'(busy), 1);
            chk("empty_en", 128'(eng_en), 0);
        end else begin
            first = 1'b1;
            for (int e = 0; e < 3; e++) begin
                if (mask[e]) begin
                    if (!first) begin
                        cnt = 0;
                        while (eng_en == 3'b000 && cnt < 20) begin tick(); cnt++; end
                        chk("en_gap", 128'(cnt), 5);
                    end
                    chk("en_value", 128'(eng_en), 128'(3'b001 << e));
                    first = 1'b0;
                    tick();
                    for (int t = 0; t < TILES; t++) begin
                        drive_tile(e, t);
                        if (t != TILES - 1) repeat (11) tick();
                    end
                end
            end
            cnt = 0;
            while (!done && cnt < 20) begin tick(); cnt++; end
            chk("done_gap", 128'(cnt), 5);
        end
        tick();
        chk("busy_after_done", 128'(busy), 0);
        chk("done_one_cycle", 128'(done), 0);
        chk("write_count", 128'(wr_cnt), 128'(exp_wr_n));
        chk("writes_left", 128'(exp_q.size()), 0);
        chk("done_pulses", 128'(done_cnt), 1);
        chk("en_pulses", 128'(en_log.size()), 128'(exp_en_n));
        idx = 0;
        for (int e = 0; e < 3; e++) begin
            if (mask[e] && idx < en_log.size()) begin
                chk("en_order", 128'(en_log[idx]), 128'(3'b001 << e));
                idx++;
            end
        end
        chk("err_after_pass", 128'(err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{mask: 3'b111, en_n: 3, wr_n: 384};
        vecs[1] = '{mask: 3'b101, en_n: 2, wr_n: 256};
        vecs[2] = '{mask: 3'b000, en_n: 0, wr_n: 0};
        vecs[3] = '{mask: 3'b010, en_n: 1, wr_n: 128};
        vecs[4] = '{mask: 3'b110, en_n: 2, wr_n: 256};

        rst_n = 1'b0; start = 1'b0; cfg_mask = 3'b000; eng_valid = 3'b000;
        q_tile = '0; k_tile = '0; v_tile = '0;
        tick(); tick();
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(done), 0);
        chk("rst_err", 128'(err), 0);
        chk("rst_en", 128'(eng_en), 0);
        chk("rst_ceb", 128'(OUT_MEM_CEB), 1);
        chk("rst_wen", 128'(OUT_MEM_WEN), 1);
        chk("rst_addr", 128'(OUT_MEM_ADDR), 0);
        chk("rst_din", OUT_MEM_DIN, 0);
        rst_n = 1'b1;
        tick();

        // Protocol errors, start-while-busy and reset during a write.
        exp_q.delete(); en_log.delete(); wr_cnt = 0;
        cfg_mask = 3'b001; start = 1'b1;
        tick();
        start = 1'b0; cfg_mask = 3'b000;
        tick();
        k_tile = tdata(1, 0); eng_valid = 3'b010;
        tick();
        eng_valid = 3'b000;
        chk("err_kvalid", 128'(err), 1);
        repeat (5) tick();
        chk("nowrite_kvalid", 128'(wr_cnt), 0);

        for (int b = 0; b < 4; b++) exp_q.push_back(mk_wr(0, 0, b));
        drive_tile(0, 0);
        tick();
        q_tile = tdata(2, 9); eng_valid = 3'b001;
        tick();
        eng_valid = 3'b000;
        repeat (9) tick();
        chk("overrun_writes", 128'(wr_cnt), 4);
        for (int b = 0; b < 4; b++) exp_q.push_back(mk_wr(0, 1, b));
        drive_tile(0, 1);
        repeat (6) tick();
        chk("overrun_err", 128'(err), 1);

        cfg_mask = 3'b110; start = 1'b1;
        tick();
        start = 1'b0; cfg_mask = 3'b000;
        repeat (4) tick();
        for (int b = 0; b < 4; b++) exp_q.push_back(mk_wr(0, 2, b));
        drive_tile(0, 2);
        repeat (6) tick();
        chk("busy_start_err_kept", 128'(err), 1);
        chk("busy_start_no_en", 128'(en_log.size()), 1);
        chk("seq_writes", 128'(wr_cnt), 12);

        for (int b = 0; b < 2; b++) exp_q.push_back(mk_wr(0, 3, b));
        drive_tile(0, 3);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstwr_ceb", 128'(OUT_MEM_CEB), 1);
        chk("rstwr_wen", 128'(OUT_MEM_WEN), 1);
        chk("rstwr_busy", 128'(busy), 0);
        chk("rstwr_err", 128'(err), 0);
        chk("rstwr_left", 128'(exp_q.size()), 0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rstwr_idle_busy", 128'(busy), 0);
        chk("rstwr_idle_ceb", 128'(OUT_MEM_CEB), 1);

        // Stray valid in IDLE sets err; the next accepted start clears it.
        eng_valid = 3'b100;
        tick();
        eng_valid = 3'b000;
        chk("err_idle_valid", 128'(err), 1);
        tick();

        for (int i = 0; i < 5; i++) begin
            run_pass(vecs[i].mask, vecs[i].en_n, vecs[i].wr_n);
            repeat (3) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
